// File: rtl/tile_cmd_issuer.sv
// tile_cmd_issuer
//
// Host-side command issuer for a compute tile. Host command descriptors are
// queued in a DEPTH-entry FIFO and serialized as 64-bit control flits onto the
// tile's NoC control channel (valid/ready). Memory-read commands (opcode 0x11)
// wait for the tile's response flit, which is captured into rsp_data with a
// one-cycle rsp_valid pulse. If no response arrives within TIMEOUT cycles,
// the sticky timeout_err flag is raised. At most one read is outstanding.
//
// Ports
//   clk, rst_n        clock (rising edge), async active-low reset
//   cmd_*             host command push interface (cmd_ready = FIFO not full)
//   ctrl_flit_out/ctrl_valid_out/ctrl_ready_in   flit channel to the tile
//   ctrl_flit_in/ctrl_valid_in/ctrl_ready_out    response channel (always sunk)
//   rsp_valid, rsp_data   captured read response
//   timeout_err, err_clear  sticky read-timeout flag and its clear
//   fifo_count, sent_count, busy   status
//
// DEPTH must be a power of two and at least 2; TIMEOUT must be 1..65535.

module tile_cmd_issuer #(
    parameter int DEPTH      = 8,
    parameter int TIMEOUT    = 256,
    parameter int NOC_FLIT_W = 64
) (
    input  logic                      clk,
    input  logic                      rst_n,
    // host command interface
    input  logic                      cmd_valid,
    output logic                      cmd_ready,
    input  logic [7:0]                cmd_opcode,
    input  logic [7:0]                cmd_row_sel,
    input  logic [15:0]               cmd_data,
    input  logic [31:0]               cmd_payload,
    // flit channel to the tile
    output logic [NOC_FLIT_W-1:0]     ctrl_flit_out,
    output logic                      ctrl_valid_out,
    input  logic                      ctrl_ready_in,
    // response channel from the tile
    input  logic [NOC_FLIT_W-1:0]     ctrl_flit_in,
    input  logic                      ctrl_valid_in,
    output logic                      ctrl_ready_out,
    // read response / error
    output logic                      rsp_valid,
    output logic [NOC_FLIT_W-1:0]     rsp_data,
    output logic                      timeout_err,
    input  logic                      err_clear,
    // status
    output logic [$clog2(DEPTH):0]    fifo_count,
    output logic [15:0]               sent_count,
    output logic                      busy
);

    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;
    localparam logic [CW-1:0] FULL_CNT  = CW'(DEPTH);
    localparam logic [15:0]   TMO_LAST  = 16'(TIMEOUT - 1);
    localparam logic [7:0]    OP_MEMRD  = 8'h11;

    typedef struct packed {
        logic [7:0]  opcode;
        logic [7:0]  row_sel;
        logic [15:0] data;
        logic [31:0] payload;
    } flit_t;

    typedef enum logic [1:0] {
        IDLE,
        SEND,
        WAIT_RSP
    } state_t;

    // ------------------------------------------------------------------
    // Command FIFO
    // ------------------------------------------------------------------
    flit_t           mem [DEPTH];
    logic [PW-1:0]   wr_ptr, rd_ptr;
    logic [CW-1:0]   count;
    logic            full, empty;
    logic            push, pop;

    assign full  = (count == FULL_CNT);
    assign empty = (count == '0);
    assign push  = cmd_valid && !full;

    // ------------------------------------------------------------------
    // Issue FSM signals
    // ------------------------------------------------------------------
    state_t          state;
    flit_t           flit_q;
    logic [15:0]     timer;
    logic            is_read;
    logic            accept;
    logic            chain;

    assign is_read = (flit_q.opcode == OP_MEMRD);
    assign accept  = ctrl_valid_out && ctrl_ready_in;
    // A read answered in its own acceptance cycle behaves like a write:
    // the next flit may follow back-to-back.
    assign chain   = accept && (!is_read || ctrl_valid_in);

    // The FSM takes the head either to start a burst from IDLE or to
    // replace the flit just accepted in SEND.
    assign pop = !empty && ((state == IDLE) || ((state == SEND) && chain));

    // Storage has no reset; contents are simply lost on reset since the
    // pointers and count return to zero.
    always_ff @(posedge clk) begin
        if (push) begin
            mem[wr_ptr] <= '{opcode:  cmd_opcode,
                             row_sel: cmd_row_sel,
                             data:    cmd_data,
                             payload: cmd_payload};
        end
    end

    // Pointers wrap naturally because DEPTH is a power of two.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + PW'(1);
            if (pop)  rd_ptr <= rd_ptr + PW'(1);
            case ({push, pop})
                2'b10:   count <= count + CW'(1);
                2'b01:   count <= count - CW'(1);
                default: count <= count;
            endcase
        end
    end

    // ------------------------------------------------------------------
    // Issue FSM with registered outputs
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state          <= IDLE;
            flit_q         <= '0;
            ctrl_valid_out <= 1'b0;
            rsp_valid      <= 1'b0;
            rsp_data       <= '0;
            timeout_err    <= 1'b0;
            sent_count     <= '0;
            timer          <= '0;
        end else begin
            rsp_valid <= 1'b0;
            // A timeout set below overrides this clear in the same cycle.
            if (err_clear) timeout_err <= 1'b0;

            case (state)
                IDLE: begin
                    if (!empty) begin
                        flit_q         <= mem[rd_ptr];
                        ctrl_valid_out <= 1'b1;
                        state          <= SEND;
                    end
                end

                SEND: begin
                    // ctrl_valid_out is always high here; flit_q holds
                    // until the tile accepts.
                    if (accept) begin
                        sent_count <= sent_count + 16'd1;
                        if (is_read && !ctrl_valid_in) begin
                            ctrl_valid_out <= 1'b0;
                            timer          <= '0;
                            state          <= WAIT_RSP;
                        end else begin
                            if (is_read) begin
                                rsp_data  <= ctrl_flit_in;
                                rsp_valid <= 1'b1;
                            end
                            if (!empty) begin
                                flit_q <= mem[rd_ptr];
                            end else begin
                                ctrl_valid_out <= 1'b0;
                                state          <= IDLE;
                            end
                        end
                    end
                end

                WAIT_RSP: begin
                    if (ctrl_valid_in) begin
                        rsp_data  <= ctrl_flit_in;
                        rsp_valid <= 1'b1;
                        state     <= IDLE;
                    end else if (timer == TMO_LAST) begin
                        timeout_err <= 1'b1;
                        state       <= IDLE;
                    end else begin
                        timer <= timer + 16'd1;
                    end
                end

                default: begin
                    ctrl_valid_out <= 1'b0;
                    state          <= IDLE;
                end
            endcase
        end
    end

    // ------------------------------------------------------------------
    // Outputs
    // ------------------------------------------------------------------
    assign ctrl_flit_out  = flit_q;
    assign cmd_ready      = !full;
    assign ctrl_ready_out = 1'b1;
    assign fifo_count     = count;
    assign busy           = (state != IDLE) || !empty;

endmodule
